// File: rtl/vout_timing_gen.sv
// Video raster timing generator: frame-buffer read requests, sync/DE re-alignment with returned
// pixels, RGB565->RGB888 expansion. Define VOUT_TESTPATTERN_EN to add the tp_sel colour-bar source.
module vout_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned DATA_DLY = 5
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        enable,
`ifdef VOUT_TESTPATTERN_EN
  input  logic        tp_sel,
`endif
  output logic        fb_vs_n,
  output logic        fb_de,
  input  logic        fb_den,
  input  logic [15:0] fb_data,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [15:0] frame_cnt,
  output logic        underflow
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic          frame_end;
  logic          hs_int, vs_int;
  logic [2:0]    dly_pipe [DATA_DLY];
  logic          tap_hs, tap_vs, tap_de;
  logic          uf_set, vs_first;
  logic [7:0]    pix_r, pix_g, pix_b;

  always_comb begin
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_nxt = '0;
          if (v_cnt == V_LAST) begin
            v_nxt     = '0;
            frame_end = 1'b1;
            if (!enable) state_nxt = IDLE;
          end else begin
            v_nxt = v_cnt + 1'b1;
          end
        end else begin
          h_nxt = h_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Counters sit at 0 in IDLE, so every request is gated by RUN.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_de   <= 1'b0;
      fb_vs_n <= 1'b1;
      hs_int  <= 1'b0;
      vs_int  <= 1'b0;
    end else begin
      fb_de   <= (state == RUN) && (h_cnt < H_ACT) && (v_cnt < V_ACT);
      fb_vs_n <= !((state == RUN) && (v_cnt >= V_SS) && (v_cnt < V_SE));
      hs_int  <= (state == RUN) && (h_cnt >= H_SS) && (h_cnt < H_SE);
      vs_int  <= (state == RUN) && (v_cnt >= V_SS) && (v_cnt < V_SE);
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DATA_DLY; i++) dly_pipe[i] <= '0;
    end else begin
      dly_pipe[0] <= {hs_int, vs_int, fb_de};
      for (int unsigned i = 1; i < DATA_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign {tap_hs, tap_vs, tap_de} = dly_pipe[DATA_DLY-1];
  assign vs_first = tap_vs && (out_vs != VS_POL);

`ifdef VOUT_TESTPATTERN_EN
  logic       tp_q;
  logic [7:0] bar_px;
  logic [2:0] bar_idx;

  // Bar position follows the aligned active pixel, so it restarts on every DE low.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q    <= 1'b0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else begin
      if (state_nxt == RUN && (state == IDLE || frame_end)) tp_q <= tp_sel;
      if (!tap_de) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == 8'd159) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    uf_set = tap_de && !fb_den;
`ifdef VOUT_TESTPATTERN_EN
    if (tp_q) begin
      uf_set = 1'b0;
      if (tap_de) begin
        pix_r = {8{~bar_idx[1]}};
        pix_g = {8{~bar_idx[2]}};
        pix_b = {8{~bar_idx[0]}};
      end
    end else
`endif
    if (tap_de && fb_den) begin
      pix_r = {fb_data[15:11], fb_data[15:13]};
      pix_g = {fb_data[10:5],  fb_data[10:9]};
      pix_b = {fb_data[4:0],   fb_data[4:2]};
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hs    <= ~HS_POL;
      out_vs    <= ~VS_POL;
      out_de    <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      underflow <= 1'b0;
    end else begin
      out_hs <= tap_hs ? HS_POL : ~HS_POL;
      out_vs <= tap_vs ? VS_POL : ~VS_POL;
      out_de <= tap_de;
      out_r  <= pix_r;
      out_g  <= pix_g;
      out_b  <= pix_b;
      if (uf_set)        underflow <= 1'b1;
      else if (vs_first) underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vout_timing_gen.sv
// Scoreboard bench for vout_timing_gen on a reduced raster: a frame-buffer model feeds random
// pixels/drops into an expected queue, a raster model predicts sync timing, a monitor compares.
`timescale 1ns/1ps
module tb_vout_timing_gen;
  localparam int unsigned HA = 16, HFP = 3, HSW = 4, HBP = 5;
  localparam int unsigned VA = 6, VFP = 2, VSW = 2, VBP = 3;
  localparam int unsigned DLY = 5;
  localparam int unsigned HT = HA + HFP + HSW + HBP;
  localparam int unsigned VT = VA + VFP + VSW + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fb_den = 1'b0;
  logic [15:0] fb_data = '0;
  logic        fb_vs_n, fb_de, out_hs, out_vs, out_de, underflow;
  logic [7:0]  out_r, out_g, out_b;
  logic [15:0] frame_cnt;
`ifdef VOUT_TESTPATTERN_EN
  logic        tp_sel = 1'b0;
`endif

  vout_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .DATA_DLY(DLY)
  ) dut (
    .video_clk(video_clk), .rst_n(rst_n), .enable(enable),
`ifdef VOUT_TESTPATTERN_EN
    .tp_sel(tp_sel),
`endif
    .fb_vs_n(fb_vs_n), .fb_de(fb_de), .fb_den(fb_den), .fb_data(fb_data),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .frame_cnt(frame_cnt), .underflow(underflow)
  );

  always #5 video_clk = ~video_clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s: condition not reached within bound at %0t", what, $time);
  endtask

  function automatic logic [23:0] expand(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  // Raster reference: position is a single linear index into the frame.
  typedef struct packed { logic de; logic hs; logic vs; logic vsf; } ras_t;

  function automatic ras_t ras_at(input bit run, input int unsigned k);
    int unsigned h, v;
    ras_t r;
    h = k % HT;
    v = k / HT;
    r.de  = run && h < HA && v < VA;
    r.hs  = run && h >= HA + HFP && h < HA + HFP + HSW;
    r.vs  = run && v >= VA + VFP && v < VA + VFP + VSW;
    r.vsf = r.vs && h == 0;
    return r;
  endfunction

  bit          m_run;
  int unsigned m_k;
  int unsigned m_frames;
  ras_t        ras_q[$];

  initial forever begin
    @(posedge video_clk);
    if (!rst_n) begin
      m_run = 1'b0; m_k = 0; m_frames = 0;
      ras_q.delete();
      repeat (DLY + 3) ras_q.push_back('0);
    end else begin
      if (m_run) begin
        if (m_k == FRAME - 1) begin
          m_frames = (m_frames + 1) % 65536;
          m_k = 0;
          m_run = enable;
        end else begin
          m_k++;
        end
      end else if (enable) begin
        m_run = 1'b1;
        m_k = 0;
      end
      ras_q.push_back(ras_at(m_run, m_k));
      void'(ras_q.pop_front());
    end
  end

  // Frame-buffer model: answers each request DLY cycles later; sometimes drops a pixel.
  typedef struct packed { logic drop; logic [23:0] rgb; } pix_t;
  pix_t        exp_q[$];
  bit          dh[$];
  bit          d_req, drop;
  int unsigned drop_req = 0;
  int unsigned drop_done = 0;
  pix_t        pe;

  initial forever begin
    @(posedge video_clk);
    #1;
    if (!rst_n) begin
      dh.delete();
      repeat (DLY) dh.push_back(1'b0);
      exp_q.delete();
      fb_den = 1'b0;
    end else begin
      dh.push_back(fb_de);
      d_req = dh.pop_front();
      fb_data = 16'($urandom);
      if (d_req) begin
        drop = ($urandom_range(0, 39) == 0);
        if (drop_req != drop_done) begin
          drop = 1'b1;
          drop_done++;
        end
        fb_den = !drop;
        pe.drop = drop;
        pe.rgb = drop ? 24'h0 : expand(fb_data);
        exp_q.push_back(pe);
      end else begin
        fb_den = ($urandom_range(0, 5) == 0);
      end
    end
  end

  int unsigned de_cnt;
  bit          exp_uf, vs_prev, uf_set;
  ras_t        t_out, t_req;
  pix_t        e;

  initial forever begin
    @(negedge video_clk);
    if (!rst_n) begin
      check("rst_fb_vs_n", fb_vs_n, 1);
      check("rst_fb_de", fb_de, 0);
      check("rst_out_hs", out_hs, !HSP);
      check("rst_out_vs", out_vs, !VSP);
      check("rst_out_de", out_de, 0);
      check("rst_rgb", {out_r, out_g, out_b}, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_underflow", underflow, 0);
      de_cnt = 0; exp_uf = 1'b0; vs_prev = 1'b0;
    end else if (ras_q.size() == DLY + 3) begin
      t_out = ras_q[0];
      t_req = ras_q[DLY + 1];
      check("fb_de", fb_de, t_req.de);
      check("fb_vs_n", fb_vs_n, !t_req.vs);
      check("out_de", out_de, t_out.de);
      check("out_hs", out_hs, t_out.hs ? HSP : !HSP);
      check("out_vs", out_vs, t_out.vs ? VSP : !VSP);
      uf_set = 1'b0;
      if (out_de === 1'b1) begin
        de_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_queue: out_de with no expected pixel at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {out_r, out_g, out_b}, e.rgb);
          uf_set = e.drop;
        end
      end else begin
        check("rgb_blank", {out_r, out_g, out_b}, 0);
      end
      if (uf_set) exp_uf = 1'b1;
      else if (t_out.vsf) exp_uf = 1'b0;
      check("underflow", underflow, exp_uf);
      check("frame_cnt", frame_cnt, 16'(m_frames));
      if (out_vs == VSP && !vs_prev) begin
        check("de_per_frame", de_cnt, HA * VA);
        de_cnt = 0;
      end
      vs_prev = (out_vs == VSP);
    end
  end

  int unsigned guard, lat;

  task automatic latency_check();
    guard = 0;
    while (!fb_de && guard < 4 * FRAME) begin @(negedge video_clk); guard++; end
    if (!fb_de) timeout("fb_de_rise");
    lat = 0;
    while (!out_de && lat < 50) begin @(negedge video_clk); lat++; end
    check("de_latency", lat, DLY + 1);
  endtask

  initial begin
    repeat (4) @(negedge video_clk);
    rst_n = 1'b1;
    repeat ($urandom_range(5, 20)) @(negedge video_clk);
    enable = 1'b1;
    latency_check();
    drop_req++;

    guard = 0;
    while (m_frames < 1 && guard < 2 * FRAME) begin @(negedge video_clk); guard++; end
    if (m_frames < 1) timeout("frame1");
    check("frame_cnt_first_wrap", frame_cnt, 1);
    drop_req++;

    guard = 0;
    while (!(m_frames >= 2 && m_k >= 2 * HT + 5) && guard < 3 * FRAME) begin
      @(negedge video_clk); guard++;
    end
    if (m_frames < 2) timeout("frame2_mid");
    enable = 1'b0;
    guard = 0;
    while (m_run && guard < 2 * FRAME) begin @(negedge video_clk); guard++; end
    if (m_run) timeout("idle");
    repeat (60) @(negedge video_clk);
    check("idle_fb_de", fb_de, 0);
    check("idle_out_de", out_de, 0);
    check("frames_stopped", frame_cnt, 3);

    repeat ($urandom_range(3, 30)) @(negedge video_clk);
    enable = 1'b1;
    guard = 0;
    while (!(m_run && m_k >= 3 * HT + 7) && guard < 2 * FRAME) begin
      @(negedge video_clk); guard++;
    end
    if (!m_run) timeout("line3");
    @(posedge video_clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_fb_de", fb_de, 0);
    check("async_fb_vs_n", fb_vs_n, 1);
    check("async_out_de", out_de, 0);
    check("async_out_hs", out_hs, !HSP);
    check("async_out_vs", out_vs, !VSP);
    check("async_rgb", {out_r, out_g, out_b}, 0);
    check("async_frame_cnt", frame_cnt, 0);
    check("async_underflow", underflow, 0);
    repeat (3) @(negedge video_clk);
    rst_n = 1'b1;
    latency_check();
    drop_req++;

    guard = 0;
    while (m_frames < 2 && guard < 3 * FRAME) begin @(negedge video_clk); guard++; end
    if (m_frames < 2) timeout("restart_frames");
    enable = 1'b0;
    guard = 0;
    while (m_run && guard < 2 * FRAME) begin @(negedge video_clk); guard++; end
    if (m_run) timeout("final_idle");
    repeat (DLY + 5) @(negedge video_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
